// File: rtl/mips_mem_port.sv
// Memory-access stage for the multicycle MIPS decoder: turns IorD/IRwrite/memwrite
// into req/ack transactions, owns the instruction and data registers, stalls the decoder.
module mips_mem_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IorD,
  input  logic              IRwrite,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] data,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             fetch;
  logic             start;
  logic             timeout;

  assign start   = IRwrite | IorD;
  // Fires on the MAX_WAIT-th REQ cycle without an ack; an ack in that cycle still wins.
  assign timeout = (state == REQ) && !mem_ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        stall = start & reset_n;
        if (start) next_state = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack || timeout) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr     <= '0;
      data      <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      fetch     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= IorD ? aluout : pc;
            mem_we    <= memwrite;
            mem_wdata <= writedata;
            mem_req   <= 1'b1;
            wait_cnt  <= '0;
            fetch     <= IRwrite;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              if (fetch) instr <= mem_rdata;
              else       data  <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (timeout) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_port.sv
// Directed self-checking bench for mips_mem_port; a small memory responder acks
// after a programmed number of wait states.
module tb_mips_mem_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IorD, IRwrite, memwrite;
  logic [31:0] pc, aluout, writedata;
  logic [31:0] instr, data;
  logic        stall, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fails  = 0;

  mips_mem_port #(.DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .IorD(IorD), .IRwrite(IRwrite), .memwrite(memwrite),
    .pc(pc), .aluout(aluout), .writedata(writedata), .instr(instr), .data(data),
    .stall(stall), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drop_controls();
    IorD = 0; IRwrite = 0; memwrite = 0;
  endtask

  // Called at a negedge; returns #1 after the negedge of the DONE cycle.
  task automatic access(input logic irw, input logic iord, input logic mw,
                        input logic [31:0] a_pc, input logic [31:0] a_alu,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic [31:0] exp_addr, input logic exp_we,
                        output int stall_cycles);
    int req_cycles;
    IRwrite = irw; IorD = iord; memwrite = mw;
    pc = a_pc; aluout = a_alu; writedata = wd;
    mem_ack = 0;
    stall_cycles = 0;
    req_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) break;
      stall_cycles++;
      if (mem_req) begin
        req_cycles++;
        n_checks++;
        if (mem_addr !== exp_addr || mem_we !== exp_we || mem_wdata !== wd) begin
          n_fails++;
          $display("FAIL req_hold: addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                   mem_addr, mem_we, mem_wdata, exp_addr, exp_we, wd);
        end
        mem_rdata = rd;
        mem_ack   = (req_cycles == waits + 1);
      end
      @(negedge clk);
      mem_ack = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 0; drop_controls();
    pc = 0; aluout = 0; writedata = 0; mem_rdata = 0; mem_ack = 0;
    #2;
    n_checks++;
    if ({instr, data, mem_addr, mem_wdata} !== '0 || {mem_req, mem_we, err, stall} !== 4'b0) begin
      n_fails++;
      $display("FAIL reset_state: instr=%h data=%h addr=%h wdata=%h req=%b we=%b err=%b stall=%b, want all 0",
               instr, data, mem_addr, mem_wdata, mem_req, mem_we, err, stall);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_fetch();
    int sc;
    access(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h8C220004, 0, 32'h40, 0, sc);
    n_checks++;
    if (sc !== 2) begin n_fails++; $display("FAIL fetch_stall: got %0d cycles, want 2", sc); end
    n_checks++;
    if (instr !== 32'h8C220004 || data !== 32'h0) begin
      n_fails++; $display("FAIL fetch_regs: instr=%h data=%h, want 8c220004 00000000", instr, data);
    end
    // ack while in DONE and then IDLE must be ignored
    drop_controls();
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    @(negedge clk);
    mem_ack = 0;
    #1;
    n_checks++;
    if (instr !== 32'h8C220004 || data !== 32'h0 || mem_req !== 0) begin
      n_fails++; $display("FAIL stray_ack: instr=%h data=%h req=%b, want 8c220004 00000000 0", instr, data, mem_req);
    end
  endtask

  task automatic test_load_waits();
    int sc;
    access(0, 1, 0, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 3, 32'h100, 0, sc);
    n_checks++;
    if (sc !== 5) begin n_fails++; $display("FAIL load_stall: got %0d cycles, want 5", sc); end
    n_checks++;
    if (data !== 32'hDEADBEEF || instr !== 32'h8C220004 || mem_req !== 0) begin
      n_fails++; $display("FAIL load_regs: data=%h instr=%h req=%b, want deadbeef 8c220004 0", data, instr, mem_req);
    end
    drop_controls();
    @(negedge clk);
  endtask

  task automatic test_store();
    int sc;
    access(0, 1, 1, 32'h44, 32'h104, 32'h12345678, 32'hBAD0BAD0, 1, 32'h104, 1, sc);
    n_checks++;
    if (sc !== 3 || data !== 32'hDEADBEEF || instr !== 32'h8C220004 || err !== 0 || mem_we !== 0) begin
      n_fails++; $display("FAIL store: stall=%0d data=%h instr=%h err=%b we=%b, want 3 deadbeef 8c220004 0 0",
                          sc, data, instr, err, mem_we);
    end
    drop_controls();
    @(negedge clk);
    // write wins over fetch: write at pc, instr untouched
    access(1, 0, 1, 32'h48, 32'h0, 32'hCAFEF00D, 32'hBAD0BAD0, 0, 32'h48, 1, sc);
    n_checks++;
    if (sc !== 2 || instr !== 32'h8C220004 || data !== 32'hDEADBEEF) begin
      n_fails++; $display("FAIL store_fetch_prio: stall=%0d instr=%h data=%h, want 2 8c220004 deadbeef", sc, instr, data);
    end
    drop_controls();
    @(negedge clk);
  endtask

  task automatic test_no_start();
    memwrite = 1; IorD = 0; IRwrite = 0;
    #1;
    n_checks++;
    if (stall !== 0) begin n_fails++; $display("FAIL no_start_stall: stall=%b, want 0", stall); end
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 0 || stall !== 0) begin
      n_fails++; $display("FAIL no_start_req: req=%b stall=%b, want 0 0", mem_req, stall);
    end
    drop_controls();
    @(negedge clk);
  endtask

  task automatic test_held_controls();
    int sc;
    access(1, 0, 0, 32'h50, 32'h0, 32'h0, 32'h11111111, 0, 32'h50, 0, sc);
    n_checks++;
    if (mem_req !== 0 || instr !== 32'h11111111) begin
      n_fails++; $display("FAIL held_done: req=%b instr=%h, want 0 11111111", mem_req, instr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 0 || stall !== 1) begin
      n_fails++; $display("FAIL held_idle: req=%b stall=%b, want 0 1", mem_req, stall);
    end
    access(1, 0, 0, 32'h54, 32'h0, 32'h0, 32'h22222222, 0, 32'h54, 0, sc);
    n_checks++;
    if (sc !== 2 || instr !== 32'h22222222) begin
      n_fails++; $display("FAIL held_second: stall=%0d instr=%h, want 2 22222222", sc, instr);
    end
    drop_controls();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int sc;
    access(0, 1, 0, 32'h0, 32'h300, 32'h0, 32'h99999999, 1000, 32'h300, 0, sc);
    n_checks++;
    if (sc !== 16 || err !== 1 || mem_req !== 0) begin
      n_fails++; $display("FAIL timeout: stall=%0d err=%b req=%b, want 16 1 0", sc, err, mem_req);
    end
    n_checks++;
    if (instr !== 32'h22222222 || data !== 32'hDEADBEEF) begin
      n_fails++; $display("FAIL timeout_regs: instr=%h data=%h, want 22222222 deadbeef", instr, data);
    end
    drop_controls();
    @(negedge clk);
    access(1, 0, 0, 32'h60, 32'h0, 32'h0, 32'h33333333, 0, 32'h60, 0, sc);
    n_checks++;
    if (sc !== 2 || instr !== 32'h33333333 || err !== 1) begin
      n_fails++; $display("FAIL after_timeout: stall=%0d instr=%h err=%b, want 2 33333333 1", sc, instr, err);
    end
    drop_controls();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int sc;
    IorD = 1; aluout = 32'h200; IRwrite = 0; memwrite = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 0;
    #1;
    n_checks++;
    if (mem_req !== 0 || data !== 32'h0 || instr !== 32'h0 || err !== 0 || stall !== 0) begin
      n_fails++; $display("FAIL reset_mid: req=%b data=%h instr=%h err=%b stall=%b, want 0 0 0 0 0",
                          mem_req, data, instr, err, stall);
    end
    @(negedge clk);
    drop_controls();
    reset_n = 1;
    mem_ack = 1; mem_rdata = 32'h44444444;
    @(negedge clk);
    mem_ack = 0;
    #1;
    n_checks++;
    if (data !== 32'h0 || instr !== 32'h0 || mem_req !== 0 || stall !== 0) begin
      n_fails++; $display("FAIL late_ack: data=%h instr=%h req=%b stall=%b, want 0 0 0 0", data, instr, mem_req, stall);
    end
    @(negedge clk);
    access(1, 0, 0, 32'h80, 32'h0, 32'h0, 32'h55555555, 0, 32'h80, 0, sc);
    n_checks++;
    if (sc !== 2 || instr !== 32'h55555555 || data !== 32'h0) begin
      n_fails++; $display("FAIL post_reset_fetch: stall=%0d instr=%h data=%h, want 2 55555555 0", sc, instr, data);
    end
    drop_controls();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_waits();
    test_store();
    test_no_start();
    test_held_controls();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
